// File: rtl/aes_round_sequencer.sv
// Purpose: iterative AES-128/192/256 encryption controller driving an external one-round datapath.
// Latency: ciphertext valid Nr clocks after the accepting edge; one block every Nr+2 clocks at best.
// Backpressure: one block in flight; in_ready stays low from accept until the ciphertext is taken.
module aes_round_sequencer #(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [127:0]            in_data,
    input  logic [(Nr+1)*128-1:0]   w,
    output logic [127:0]            rnd_state,
    output logic [127:0]            rnd_key,
    output logic                    rnd_last,
    input  logic [127:0]            rnd_result,
    output logic [$clog2(Nr+1)-1:0] round_idx,
    output logic                    busy,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [127:0]            out_data
);

    localparam int RW = $clog2(Nr + 1);
    localparam logic [RW-1:0] LAST = RW'(Nr);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t         fsm;
    logic [127:0] state_q;

    // AES only defines 4/6/8-word keys with 10/12/14 rounds; anything else is a wiring mistake.
    if (Nr != Nk + 6) begin : g_bad_round_count
        $error("aes_round_sequencer: Nr must equal Nk+6");
    end

    assign rnd_state = state_q;

    // Round key selection: key 0 sits in the top 128 bits of w; round_idx is 0 outside RUN,
    // so the datapath sees key 0 whenever it is idle.
    always_comb begin
        rnd_key = w[(Nr+1)*128-1 -: 128];
        for (int r = 1; r <= Nr; r++) begin
            if (round_idx == RW'(r)) begin
                rnd_key = w[(Nr+1-r)*128-1 -: 128];
            end
        end
    end

    // Controller FSM with all handshake and round outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            state_q   <= '0;
            round_idx <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            rnd_last  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        // Initial AddRoundKey folded into the load.
                        state_q   <= in_data ^ w[(Nr+1)*128-1 -: 128];
                        round_idx <= RW'(1);
                        rnd_last  <= (LAST == RW'(1));
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    state_q <= rnd_result;
                    if (round_idx == LAST) begin
                        out_data  <= rnd_result;
                        out_valid <= 1'b1;
                        round_idx <= '0;
                        rnd_last  <= 1'b0;
                        busy      <= 1'b0;
                        fsm       <= DONE;
                    end else begin
                        round_idx <= round_idx + 1'b1;
                        // Flag the next round as final so the datapath skips MixColumns.
                        rnd_last  <= (round_idx == LAST - 1'b1);
                    end
                end
                DONE: begin
                    // out_data is left untouched here so it stays stable under backpressure.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

endmodule
